fir_serial_mac: RTL and testbench

//  Parametrised symmetric odd-length FIR low-pass for PPG samples. Uses one time-shared multiplier, one tap pair per clk.

---
 rtl/fir_pkg.sv | 20 ++
 rtl/fir_delay_line.sv | 33 +++
 rtl/fir_serial_mac.sv | 157 +++++++++++++++
 tb/tb_fir_serial_mac.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and default coefficient table for the serial-MAC FIR.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  localparam int DEFAULT_TAPS = 16;

  // Half of a 31-tap symmetric low-pass; entry 15 is the centre tap (gain 1028/1024).
  localparam logic signed [7:0] FIR_DEFAULT_COEF [DEFAULT_TAPS] = '{
    8'sd3,  8'sd4,  8'sd6,  8'sd8,  8'sd12, 8'sd17, 8'sd23, 8'sd29,
    8'sd36, 8'sd43, 8'sd50, 8'sd56, 8'sd61, 8'sd65, 8'sd67, 8'sd68
  };

  function automatic int default_coef(input int k);
    logic [3:0] idx;
    idx = k[3:0];
    return (k < DEFAULT_TAPS) ? int'(FIR_DEFAULT_COEF[idx]) : 0;
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// rtl/fir_delay_line.sv - circular sample history with one write port and two async read ports.
module fir_delay_line #(
  parameter int DATA_W = 10,
  parameter int NTAPS  = 31
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     we,
  input  logic [$clog2(NTAPS)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(NTAPS)-1:0] raddr_a,
  input  logic [$clog2(NTAPS)-1:0] raddr_b,
  output logic [DATA_W-1:0]        rdata_a,
  output logic [DATA_W-1:0]        rdata_b
);

  logic [DATA_W-1:0] mem [NTAPS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) mem[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NTAPS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/fir_serial_mac.sv
// rtl/fir_serial_mac.sv - symmetric odd-length FIR, one tap pair per clock through a single multiplier.
module fir_serial_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int COEF_W = 8,
  parameter int NTAPS  = 31,
  parameter int SHIFT  = 10,
  parameter int OUT_W  = 10
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_W-1:0]               in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [OUT_W-1:0]                out_data,
  input  logic                            coef_we,
  input  logic [$clog2((NTAPS+1)/2)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]               coef_data,
  output logic                            coef_err,
  output logic                            busy
);

  localparam int HALF   = (NTAPS + 1) / 2;
  localparam int KW     = $clog2(HALF);
  localparam int PTR_W  = $clog2(NTAPS);
  localparam int ACC_W  = DATA_W + 1 + COEF_W + KW + 1;
  localparam int PROD_W = COEF_W + DATA_W + 2;
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << OUT_W) - 1);

  state_t                   state;
  logic [PTR_W-1:0]         wr_ptr;
  logic [KW-1:0]            k;
  logic signed [ACC_W-1:0]  acc;
  logic signed [COEF_W-1:0] coef [HALF];

  logic [PTR_W-1:0]         raddr_a, raddr_b;
  logic [DATA_W-1:0]        x_a, x_b;
  logic                     centre, accept, coef_ok;
  logic [DATA_W:0]          pair;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_next, shifted;
  logic [OUT_W-1:0]         sat_val;
  int                       ia, ib;

  assign accept  = (state == IDLE) && in_valid;
  assign centre  = (k == KW'(HALF - 1));
  assign coef_ok = (state == IDLE) && ({1'b0, coef_addr} < (KW+1)'(HALF));

  fir_delay_line #(.DATA_W(DATA_W), .NTAPS(NTAPS)) u_delay (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .we      (accept && !clear),
    .waddr   (wr_ptr),
    .wdata   (in_data),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .rdata_a (x_a),
    .rdata_b (x_b)
  );

  // During MAC wr_ptr already points past the newest sample: a = x[n-k], b = x[n-(NTAPS-1-k)].
  always_comb begin
    ia = int'(wr_ptr) + NTAPS - 1 - int'(k);
    if (ia >= NTAPS) ia = ia - NTAPS;
    ib = int'(wr_ptr) + int'(k);
    if (ib >= NTAPS) ib = ib - NTAPS;
    raddr_a = PTR_W'(ia);
    raddr_b = PTR_W'(ib);
  end

  always_comb begin
    pair     = centre ? {1'b0, x_a} : ({1'b0, x_a} + {1'b0, x_b});
    prod     = PROD_W'(coef[k]) * PROD_W'($signed({1'b0, pair}));
    acc_next = acc + ACC_W'(prod);
    shifted  = acc_next >>> SHIFT;
    if (shifted < 0)
      sat_val = '0;
    else if (shifted > OUT_MAX)
      sat_val = '1;
    else
      sat_val = shifted[OUT_W-1:0];
  end

  // Coefficient bank survives clear; a clear cycle swallows any concurrent write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < HALF; i++) coef[i] <= COEF_W'(default_coef(i));
      coef_err <= 1'b0;
    end else begin
      coef_err <= 1'b0;
      if (coef_we && !clear) begin
        if (coef_ok) coef[coef_addr] <= coef_data;
        else         coef_err        <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      k         <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      k         <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            wr_ptr   <= (wr_ptr == PTR_W'(NTAPS - 1)) ? '0 : wr_ptr + 1'b1;
            acc      <= '0;
            k        <= '0;
            state    <= MAC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        MAC: begin
          acc <= acc_next;
          if (centre) begin
            state     <= OUT;
            out_valid <= 1'b1;
            out_data  <= sat_val;
          end else begin
            k <= k + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_serial_mac.sv
// tb/tb_fir_serial_mac.sv - directed self-checking bench for fir_serial_mac at default parameters.
module tb_fir_serial_mac;

  logic       clk = 1'b0;
  logic       reset, clear, in_valid, in_ready, out_valid, out_ready;
  logic       coef_we, coef_err, busy;
  logic [9:0] in_data, out_data;
  logic [3:0] coef_addr;
  logic [7:0] coef_data;

  int vectors     = 0;
  int miscompares = 0;

  // 1023 * c >> 10 == c - 1 for the default positive taps
  int imp_half [16] = '{2, 3, 5, 7, 11, 16, 22, 28, 35, 42, 49, 55, 60, 64, 66, 67};

  fir_serial_mac dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef_err  (coef_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic int imp_exp(input int n);
    if (n < 16)      return imp_half[n];
    else if (n < 31) return imp_half[30 - n];
    else             return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_result(output int cyc, output logic [9:0] r);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 100);
    check("out_valid_seen", {31'd0, out_valid}, 32'd1);
    r = out_data;
  endtask

  task automatic send(input logic [9:0] d, input bit chk, input int exp_d, input string tag);
    int         cyc;
    logic [9:0] r;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    wait_result(cyc, r);
    check({tag, "_latency"}, cyc, 32'd17);
    if (chk) check({tag, "_data"}, {22'd0, r}, exp_d);
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic wr_coef(input logic [3:0] a, input logic [7:0] d);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(negedge clk);
    coef_we = 1'b0;
    check("coef_err_idle_write", {31'd0, coef_err}, 32'd0);
  endtask

  initial begin
    int         cyc;
    logic [9:0] r;
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {22'd0, out_data},  32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_coef_err",  {31'd0, coef_err},  32'd0);
    reset = 1'b0;
    @(negedge clk);

    // impulse response, back-to-back samples
    for (int n = 0; n < 32; n++)
      send((n == 0) ? 10'd1023 : 10'd0, 1'b1, imp_exp(n), $sformatf("imp%0d", n));

    do_clear();
    for (int n = 0; n < 40; n++)
      send(10'd1000, n >= 30, 1003, $sformatf("dc%0d", n));

    do_clear();
    for (int n = 0; n < 31; n++)
      send(10'd1023, n == 30, 1023, $sformatf("sat%0d", n));

    // backpressure: result held, stray in_valid ignored
    do_clear();
    out_ready = 1'b0;
    in_data   = 10'd1023;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_data = 10'd500;
    wait_result(cyc, r);
    check("bp_latency", cyc, 32'd17);
    check("bp_first", {22'd0, r}, 32'd2);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_data",  {22'd0, out_data},  32'd2);
      check("bp_in_ready",   {31'd0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, in_ready},  32'd1);
    send(10'd0, 1'b1, 3, "bp_next");

    // coefficient writes
    do_clear();
    wr_coef(4'd0, 8'd0);
    send(10'd1023, 1'b1, 0, "coef0_zero");
    in_data  = 10'd0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    coef_we   = 1'b1;
    coef_addr = 4'd0;
    coef_data = 8'd100;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    @(negedge clk);
    check("coef_err_mac_pulse", {31'd0, coef_err}, 32'd1);
    @(negedge clk);
    check("coef_err_mac_end", {31'd0, coef_err}, 32'd0);
    wait_result(cyc, r);
    check("coef_mac_second_out", {22'd0, r}, 32'd3);
    @(negedge clk);
    do_clear();
    send(10'd1023, 1'b1, 0, "coef0_unchanged");

    // centre tap -128 with same-cycle restore of tap 0
    do_clear();
    wr_coef(4'd15, 8'h80);
    coef_we   = 1'b1;
    coef_addr = 4'd0;
    coef_data = 8'd3;
    send(10'd1023, 1'b1, 2, "same_cycle_write");
    for (int n = 1; n < 16; n++)
      send(10'd0, 1'b1, (n == 15) ? 0 : imp_exp(n), $sformatf("neg_centre%0d", n));

    // reset mid-MAC restores default coefficients
    send(10'd0, 1'b0, 0, "pre_reset");
    in_data  = 10'd1000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_mac_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("reset_mid_valid", {31'd0, out_valid}, 32'd0);
    check("reset_mid_ready", {31'd0, in_ready},  32'd1);
    check("reset_mid_busy",  {31'd0, busy},      32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 16; n++)
      send((n == 0) ? 10'd1023 : 10'd0, 1'b1, imp_exp(n), $sformatf("post_reset%0d", n));

    // clear mid-MAC
    in_data  = 10'd1000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    do_clear();
    check("clear_mid_valid", {31'd0, out_valid}, 32'd0);
    check("clear_mid_ready", {31'd0, in_ready},  32'd1);
    send(10'd1023, 1'b1, 2, "post_clear0");
    send(10'd0,    1'b1, 3, "post_clear1");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
